display_reader: RTL and testbench
=================================

DISPLAY_READER -- requirements
Module: display_reader

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 2: consecutive identical samples needed to accept a new display pattern (legal range 1..15).
REQ-002 SHALL have parameter MAX_VALUE, default 99: wrap point of the observed count.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port BCD_digit_1, input, 7 bits: tens-digit segments, order abcdefg (bit6=a), active-low.
REQ-006 SHALL have port BCD_digit_2, input, 7 bits: units-digit segments, same encoding as BCD_digit_1.
REQ-007 SHALL have port tens, output, 4 bits: decoded tens digit of the last accepted pattern.
REQ-008 SHALL have port units, output, 4 bits: decoded units digit of the last accepted pattern.
REQ-009 SHALL have port value, output, 7 bits: binary value, tens*10+units.
REQ-010 SHALL have port valid, output, 1 bit: one-cycle pulse when a new pattern is accepted.
REQ-011 SHALL have port code_error, output, 1 bit: sticky flag; an accepted pattern contained a non-digit segment code.
REQ-012 SHALL have port step_error, output, 1 bit: sticky flag; an accepted value differed from the previous one by something other than +1 mod (MAX_VALUE+1).

Function
REQ-013 SHALL decode each digit with the table 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100; any other code SHALL be illegal.
REQ-014 SHALL register both segment inputs once; the raw pair SHALL be compared against the previously registered pair each cycle.
REQ-015 SHALL run FSM states WAIT_STABLE, ACCEPT and HOLD.
REQ-016 In WAIT_STABLE, a pair matching the previous pair SHALL increment the stability counter; a change SHALL reload it to 1.
REQ-017 When the stability counter reaches STABLE_CYCLES, the FSM SHALL go to ACCEPT.
REQ-018 ACCEPT SHALL last exactly one cycle; in it the block SHALL update tens, units and value, pulse valid, evaluate both error flags, then go to HOLD.
REQ-019 HOLD SHALL persist while the input pair equals the accepted pair; any change SHALL go to WAIT_STABLE with the stability counter at 1.
REQ-020 Latency: valid SHALL rise STABLE_CYCLES+1 edges after the first edge on which the new pair is registered.
REQ-021 On an illegal code, the block SHALL set code_error, leave tens, units and value unchanged, still pulse valid, and SHALL NOT evaluate step_error.
REQ-022 The first legal acceptance after reset SHALL only seed the previous value; step_error SHALL NOT be evaluated on it.
REQ-023 Wrap: previous=MAX_VALUE followed by 0 SHALL be a legal step.
REQ-024 A repeated value SHALL be impossible to accept, because HOLD absorbs it.
REQ-025 A decoded value greater than MAX_VALUE SHALL set code_error.
REQ-026 An input change in the same cycle as ACCEPT SHALL be ignored for that accept, then handled from HOLD on the next cycle.
REQ-027 value SHALL be computed in 7 bits with no overflow for inputs 0..99.

Reset
REQ-028 Asserting reset SHALL immediately clear tens, units, value, valid, code_error, step_error, the stability counter, the registered inputs and the seeded flag, and SHALL select WAIT_STABLE.
REQ-029 Reset asserted mid-WAIT_STABLE SHALL discard all partial stability progress.
REQ-030 The sticky error flags SHALL clear only through reset.

Structure
REQ-031 The segment code constants and the FSM state enum SHALL live in the shared package display_pkg.
REQ-032 The design SHALL use one sub-module, seg7_decoder: combinational, 7-bit code in, 4-bit digit plus illegal flag out, instantiated twice.

Verification
REQ-033 Reset, then hold tens=0100000 and units=0010010 for 3 cycles -> valid pulses once; value=62; tens=6; units=2; both error flags 0.
REQ-034 Sequence 62 -> 63 -> 64, each pattern held 3 cycles -> three valid pulses; step_error stays 0.
REQ-035 Sequence 62 -> 61 -> valid pulses and step_error=1; it stays 1 until reset.
REQ-036 Units=1111111 held 3 cycles -> code_error=1; value keeps its prior value.
REQ-037 Sequence 99 -> 00 -> step_error stays 0; value=0.
REQ-038 Units glitching every cycle for 10 cycles -> no valid pulse; then reset asserted mid-sequence -> all outputs read 0 immediately.

Source files
------------

// File: rtl/display_pkg.sv
// Shared definitions for the seven-segment display reader: the active-low
// segment codes for the ten decimal digits, the FSM state type and a small
// helper that turns a tens/units pair into its binary value.
package display_pkg;

  // Segment order is abcdefg with bit 6 = a; a lit segment reads as 0.
  localparam logic [6:0] SEG_0 = 7'b0000001;
  localparam logic [6:0] SEG_1 = 7'b1001111;
  localparam logic [6:0] SEG_2 = 7'b0010010;
  localparam logic [6:0] SEG_3 = 7'b0000110;
  localparam logic [6:0] SEG_4 = 7'b1001100;
  localparam logic [6:0] SEG_5 = 7'b0100100;
  localparam logic [6:0] SEG_6 = 7'b0100000;
  localparam logic [6:0] SEG_7 = 7'b0001111;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0000100;

  typedef enum logic [1:0] {
    WAIT_STABLE = 2'd0,
    ACCEPT      = 2'd1,
    HOLD        = 2'd2
  } state_t;

  // tens*10 + units as tens*8 + tens*2 + units; 99 fits in 7 bits.
  function automatic logic [6:0] bcd_to_bin(input logic [3:0] t, input logic [3:0] u);
    return {t, 3'b000} + {2'b00, t, 1'b0} + {3'b000, u};
  endfunction

endpackage

// File: rtl/seg7_decoder.sv
// Combinational decoder from one active-low seven-segment code to a decimal
// digit. Any code outside the ten digit shapes is flagged as illegal and the
// digit output is forced to 0 so downstream logic never sees stale data.
module seg7_decoder
  import display_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] digit,
  output logic       illegal
);

  // Table lookup of the ten legal shapes; everything else is illegal.
  always_comb begin
    digit   = 4'd0;
    illegal = 1'b0;
    case (seg)
      SEG_0:   digit = 4'd0;
      SEG_1:   digit = 4'd1;
      SEG_2:   digit = 4'd2;
      SEG_3:   digit = 4'd3;
      SEG_4:   digit = 4'd4;
      SEG_5:   digit = 4'd5;
      SEG_6:   digit = 4'd6;
      SEG_7:   digit = 4'd7;
      SEG_8:   digit = 4'd8;
      SEG_9:   digit = 4'd9;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/display_reader.sv
// Watches a two-digit seven-segment display, waits for the pattern to settle,
// then reports the decoded value once per new pattern. Illegal shapes and
// values that do not advance by exactly one (with wrap) raise sticky flags.
module display_reader
  import display_pkg::*;
#(
  parameter int STABLE_CYCLES = 2,
  parameter int MAX_VALUE     = 99
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] BCD_digit_1,
  input  logic [6:0] BCD_digit_2,
  output logic [3:0] tens,
  output logic [3:0] units,
  output logic [6:0] value,
  output logic       valid,
  output logic       code_error,
  output logic       step_error
);

  localparam logic [3:0] STABLE_TARGET = 4'(STABLE_CYCLES);
  localparam logic [6:0] MAX_CODE      = 7'(MAX_VALUE);

  logic [13:0] pair_in;
  state_t      state_q, state_d;
  logic [13:0] seg_q, seg_d;
  logic [13:0] cand_q, cand_d;
  logic [3:0]  stab_q, stab_d;
  logic [3:0]  tens_q, tens_d;
  logic [3:0]  units_q, units_d;
  logic [6:0]  value_q, value_d;
  logic        valid_q, valid_d;
  logic        code_error_q, code_error_d;
  logic        step_error_q, step_error_d;
  logic        seeded_q, seeded_d;

  logic [3:0]  dec_tens, dec_units;
  logic        ill_tens, ill_units;
  logic [6:0]  cand_value;
  logic [6:0]  next_expected;

  assign pair_in = {BCD_digit_1, BCD_digit_2};

  // The candidate pair is frozen when the FSM commits to ACCEPT, so an input
  // change arriving during ACCEPT cannot corrupt the value being reported.
  seg7_decoder u_dec_tens (
    .seg     (cand_q[13:7]),
    .digit   (dec_tens),
    .illegal (ill_tens)
  );

  seg7_decoder u_dec_units (
    .seg     (cand_q[6:0]),
    .digit   (dec_units),
    .illegal (ill_units)
  );

  assign cand_value    = bcd_to_bin(dec_tens, dec_units);
  assign next_expected = (value_q == MAX_CODE) ? 7'd0 : value_q + 7'd1;

  // Next-state logic: stability counting, acceptance and hold-off of repeats.
  always_comb begin
    state_d      = state_q;
    seg_d        = pair_in;
    cand_d       = cand_q;
    stab_d       = stab_q;
    tens_d       = tens_q;
    units_d      = units_q;
    value_d      = value_q;
    valid_d      = 1'b0;
    code_error_d = code_error_q;
    step_error_d = step_error_q;
    seeded_d     = seeded_q;

    case (state_q)
      WAIT_STABLE: begin
        if (stab_q >= STABLE_TARGET) begin
          state_d = ACCEPT;
          cand_d  = seg_q;
        end else if (pair_in == seg_q) begin
          stab_d = stab_q + 4'd1;
        end else begin
          stab_d = 4'd1;
        end
      end

      ACCEPT: begin
        valid_d = 1'b1;
        state_d = HOLD;
        if (ill_tens || ill_units || (cand_value > MAX_CODE)) begin
          code_error_d = 1'b1;
        end else begin
          if (seeded_q && (cand_value != next_expected)) begin
            step_error_d = 1'b1;
          end
          tens_d   = dec_tens;
          units_d  = dec_units;
          value_d  = cand_value;
          seeded_d = 1'b1;
        end
      end

      HOLD: begin
        if (pair_in != cand_q) begin
          state_d = WAIT_STABLE;
          stab_d  = 4'd1;
        end
      end

      default: state_d = WAIT_STABLE;
    endcase
  end

  // State and registered outputs, all cleared asynchronously by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= WAIT_STABLE;
      seg_q        <= '0;
      cand_q       <= '0;
      stab_q       <= '0;
      tens_q       <= '0;
      units_q      <= '0;
      value_q      <= '0;
      valid_q      <= 1'b0;
      code_error_q <= 1'b0;
      step_error_q <= 1'b0;
      seeded_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      seg_q        <= seg_d;
      cand_q       <= cand_d;
      stab_q       <= stab_d;
      tens_q       <= tens_d;
      units_q      <= units_d;
      value_q      <= value_d;
      valid_q      <= valid_d;
      code_error_q <= code_error_d;
      step_error_q <= step_error_d;
      seeded_q     <= seeded_d;
    end
  end

  assign tens       = tens_q;
  assign units      = units_q;
  assign value      = value_q;
  assign valid      = valid_q;
  assign code_error = code_error_q;
  assign step_error = step_error_q;

endmodule

// File: tb/tb_display_reader.sv
// Scoreboard bench for display_reader: stimulus pushes the expected report for
// each pattern, a monitor pops and compares whenever valid is seen.
module tb_display_reader;

  // Hand-written segment shapes (abcdefg, active-low).
  localparam logic [6:0] S0 = 7'b0000001;
  localparam logic [6:0] S1 = 7'b1001111;
  localparam logic [6:0] S2 = 7'b0010010;
  localparam logic [6:0] S3 = 7'b0000110;
  localparam logic [6:0] S4 = 7'b1001100;
  localparam logic [6:0] S5 = 7'b0100100;
  localparam logic [6:0] S6 = 7'b0100000;
  localparam logic [6:0] S9 = 7'b0000100;
  localparam logic [6:0] SX = 7'b1111111;

  // Edges from the edge after which a pattern is driven until valid is high:
  // one edge to register it, then STABLE_CYCLES(2)+1 more.
  localparam int LATENCY = 4;

  typedef struct {
    logic [3:0] tens;
    logic [3:0] units;
    logic [6:0] value;
    logic       code_err;
    logic       step_err;
    int         edge_no;
  } exp_t;

  logic       clk;
  logic       reset;
  logic [6:0] digit1, digit2;
  logic [3:0] tens, units;
  logic [6:0] value;
  logic       valid, code_error, step_error;

  int   tests_run    = 0;
  int   tests_failed = 0;
  int   edge_count   = 0;
  exp_t exp_q[$];
  exp_t mon_e;
  exp_t none_e;

  display_reader #(.STABLE_CYCLES(2), .MAX_VALUE(99)) dut (
    .clk         (clk),
    .reset       (reset),
    .BCD_digit_1 (digit1),
    .BCD_digit_2 (digit2),
    .tens        (tens),
    .units       (units),
    .value       (value),
    .valid       (valid),
    .code_error  (code_error),
    .step_error  (step_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) edge_count <= edge_count + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic exp_t mk_exp(input logic [3:0] t, input logic [3:0] u, input logic [6:0] v,
                                  input logic ce, input logic se);
    exp_t e;
    e.tens     = t;
    e.units    = u;
    e.value    = v;
    e.code_err = ce;
    e.step_err = se;
    e.edge_no  = 0;
    return e;
  endfunction

  // Called just after a rising edge; drives a pattern and holds it.
  task automatic applyStimulus(input logic [6:0] d1, input logic [6:0] d2, input int hold_cycles,
                               input bit expect_valid, input exp_t e);
    digit1 = d1;
    digit2 = d2;
    if (expect_valid) begin
      e.edge_no = edge_count + LATENCY;
      exp_q.push_back(e);
    end
    repeat (hold_cycles) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One idle cycle so the last valid is observed, then a reset pulse.
  task automatic pulse_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    checkOutput({tag, "_tens"}, 32'(tens), 32'd0);
    checkOutput({tag, "_units"}, 32'(units), 32'd0);
    checkOutput({tag, "_value"}, 32'(value), 32'd0);
    checkOutput({tag, "_valid"}, 32'(valid), 32'd0);
    checkOutput({tag, "_code_error"}, 32'(code_error), 32'd0);
    checkOutput({tag, "_step_error"}, 32'(step_error), 32'd0);
  endtask

  // Monitor: every valid pulse must match the oldest expected report.
  always @(negedge clk) begin
    if (!reset && valid) begin
      if (exp_q.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("[TB] FAIL unexpected_valid: got value %0d at edge %0d, expected no pulse", value, edge_count);
      end else begin
        mon_e = exp_q.pop_front();
        checkOutput("tens", 32'(tens), 32'(mon_e.tens));
        checkOutput("units", 32'(units), 32'(mon_e.units));
        checkOutput("value", 32'(value), 32'(mon_e.value));
        checkOutput("code_error", 32'(code_error), 32'(mon_e.code_err));
        checkOutput("step_error", 32'(step_error), 32'(mon_e.step_err));
        checkOutput("valid_edge", 32'(edge_count), 32'(mon_e.edge_no));
      end
    end
  end

  initial begin
    none_e = mk_exp(4'd0, 4'd0, 7'd0, 1'b0, 1'b0);
    reset  = 1'b1;
    digit1 = SX;
    digit2 = SX;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    reset = 1'b0;

    // 62, 63, 64 ascend cleanly; 61 is a backwards step; 62 keeps it sticky.
    applyStimulus(S6, S2, 4, 1'b1, mk_exp(4'd6, 4'd2, 7'd62, 1'b0, 1'b0));
    applyStimulus(S6, S3, 4, 1'b1, mk_exp(4'd6, 4'd3, 7'd63, 1'b0, 1'b0));
    applyStimulus(S6, S4, 4, 1'b1, mk_exp(4'd6, 4'd4, 7'd64, 1'b0, 1'b0));
    applyStimulus(S6, S1, 4, 1'b1, mk_exp(4'd6, 4'd1, 7'd61, 1'b0, 1'b1));
    applyStimulus(S6, S2, 4, 1'b1, mk_exp(4'd6, 4'd2, 7'd62, 1'b0, 1'b1));
    // Blank units digit: code error, value keeps 62.
    applyStimulus(S6, SX, 4, 1'b1, mk_exp(4'd6, 4'd2, 7'd62, 1'b1, 1'b1));

    // Fresh start: 99 seeds, 00 is the legal wrap, 55 is a bad step.
    pulse_reset();
    applyStimulus(S9, S9, 4, 1'b1, mk_exp(4'd9, 4'd9, 7'd99, 1'b0, 1'b0));
    applyStimulus(S0, S0, 4, 1'b1, mk_exp(4'd0, 4'd0, 7'd0, 1'b0, 1'b0));
    applyStimulus(S5, S5, 4, 1'b1, mk_exp(4'd5, 4'd5, 7'd55, 1'b0, 1'b1));

    // Units flicker every cycle: nothing settles, so no report.
    for (int i = 0; i < 10; i++) begin
      applyStimulus(S5, (i % 2 == 0) ? S1 : S2, 1, 1'b0, none_e);
    end
    digit2 = S3;
    reset  = 1'b1;
    #1;
    check_all_zero("mid_reset");
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // After reset the first acceptance only seeds, so 30 raises no step error.
    applyStimulus(S3, S0, 4, 1'b1, mk_exp(4'd3, 4'd0, 7'd30, 1'b0, 1'b0));
    repeat (4) @(posedge clk);
    #1;
    checkOutput("pending_reports", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
